// File: rtl/buzzer_pkg.sv
// Shared constants for the buzzer tone path. The PWM generator and the
// frequency meter both import this package so that they agree on the clock
// rate that defines the Hz unit and on the width of a frequency word.
package buzzer_pkg;

  localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;
  localparam int unsigned FREQ_W_DEFAULT = 32;

  // What the meter does in a given cycle, decoded from enable and the gate
  // counter position.
  typedef enum logic [1:0] {
    PH_IDLE,   // disabled: counters held cleared
    PH_COUNT,  // inside the window: accumulate edges
    PH_CLOSE   // last gate cycle: publish result and restart
  } meter_phase_e;

endpackage

// File: rtl/tone_sync_edge.sv
// Brings the asynchronous tone pin into the i_clk domain through a two-stage
// synchronizer, then delays it one more cycle to detect rising edges.
// o_rise is a single-cycle strobe per synchronized low-to-high transition.
module tone_sync_edge (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tone,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Synchronizer chain (s1, s2) plus the one-cycle delay stage s3.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the value its predecessor held before this edge.
    if (i_reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_tone;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/buzzer_freq_meter.sv
// Frequency meter for the buzzer tone line. Counts synchronized rising edges
// of i_tone over a gate window of GATE_CYCLES clocks and publishes the count
// on o_freq, with a one-cycle o_valid strobe per completed window. With
// GATE_CYCLES equal to CLK_HZ the count is directly in Hz. GATE_CYCLES must
// be at least 4.
module buzzer_freq_meter
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_HZ      = CLK_HZ_DEFAULT,
  parameter int unsigned GATE_CYCLES = CLK_HZ,
  parameter int unsigned FREQ_W      = FREQ_W_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_tone,
  output logic [FREQ_W-1:0] o_freq,
  output logic              o_valid,
  output logic              o_overflow,
  output logic              o_no_signal
);

  localparam int unsigned         GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0]   GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  logic [GATE_W-1:0] r_gate_cnt;
  logic [FREQ_W-1:0] r_edge_cnt;
  logic              r_sat;
  logic [FREQ_W-1:0] r_freq;
  logic              r_valid;
  logic              r_overflow;
  logic              r_no_signal;

  logic              w_rise;
  logic              w_last;
  logic [FREQ_W:0]   w_sum;
  logic              w_carry;
  logic [FREQ_W-1:0] w_result;
  logic              w_result_sat;
  meter_phase_e      w_phase;

  tone_sync_edge u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_tone  (i_tone),
    .o_rise  (w_rise)
  );

  assign w_last = (r_gate_cnt == GATE_LAST);

  // Saturating add of this cycle's rise strobe. The same value feeds both the
  // running count and, on the last gate cycle, the published result, so an
  // edge landing on the closing cycle is never lost.
  assign w_sum        = {1'b0, r_edge_cnt} + {{FREQ_W{1'b0}}, w_rise};
  assign w_carry      = w_sum[FREQ_W];
  assign w_result     = w_carry ? {FREQ_W{1'b1}} : w_sum[FREQ_W-1:0];
  assign w_result_sat = r_sat | w_carry;

  // Decode what this cycle does within the measurement window.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    w_phase = PH_IDLE;
    if (i_enable) begin
      w_phase = w_last ? PH_CLOSE : PH_COUNT;
    end
  end

  // Gate counter: 0..GATE_CYCLES-1, wraps on the last cycle, parked at 0
  // while disabled so a fresh full window starts on enable.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_gate_cnt <= '0;
    end else begin
      case (w_phase)
        PH_COUNT: r_gate_cnt <= r_gate_cnt + GATE_W'(1);
        PH_CLOSE: r_gate_cnt <= '0;
        default:  r_gate_cnt <= '0;
      endcase
    end
  end

  // Edge counter with sticky saturation flag, cleared when a window closes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
    end else begin
      case (w_phase)
        PH_COUNT: begin
          r_edge_cnt <= w_result;
          r_sat      <= w_result_sat;
        end
        default: begin
          r_edge_cnt <= '0;
          r_sat      <= 1'b0;
        end
      endcase
    end
  end

  // Output registers: updated only as a window closes, held otherwise.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_freq      <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_no_signal <= 1'b1;
    end else begin
      r_valid <= (w_phase == PH_CLOSE);
      if (w_phase == PH_CLOSE) begin
        r_freq      <= w_result;
        r_overflow  <= w_result_sat;
        r_no_signal <= (w_result == '0);
      end
    end
  end

  assign o_freq      = r_freq;
  assign o_valid     = r_valid;
  assign o_overflow  = r_overflow;
  assign o_no_signal = r_no_signal;

endmodule

// File: tb/tb_buzzer_freq_meter.sv
// Directed bench for buzzer_freq_meter with a 1000-cycle gate and 8-bit
// frequency word. Expected window results are queued when the tone stimulus
// is set up and compared as each o_valid strobe appears. Outputs are sampled
// on the falling clock edge.
module tb_buzzer_freq_meter;

  localparam int GATE = 1000;
  localparam int FW   = 8;

  logic          clk;
  logic          i_reset;
  logic          i_enable;
  logic          i_tone;
  logic [FW-1:0] o_freq;
  logic          o_valid;
  logic          o_overflow;
  logic          o_no_signal;

  buzzer_freq_meter #(
    .CLK_HZ      (GATE),
    .GATE_CYCLES (GATE),
    .FREQ_W      (FW)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_tone      (i_tone),
    .o_freq      (o_freq),
    .o_valid     (o_valid),
    .o_overflow  (o_overflow),
    .o_no_signal (o_no_signal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Tone source: period 0 drives the static tone_level, otherwise a square
  // wave, low for the first half period. Changes just after a falling edge.
  int   tone_period = 0;
  logic tone_level  = 1'b0;
  int   tone_phase  = 0;

  initial begin
    i_tone = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (tone_period == 0) begin
        i_tone     = tone_level;
        tone_phase = 0;
      end else begin
        i_tone     = (tone_phase >= tone_period / 2);
        tone_phase = (tone_phase + 1 == tone_period) ? 0 : tone_phase + 1;
      end
    end
  end

  typedef struct packed {
    logic          skip;
    logic [FW-1:0] freq;
    logic          ovf;
    logic          nosig;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fails  = 0;

  // Model of the last reported window, used to check the held outputs.
  logic [FW-1:0] held_freq;
  logic          held_ovf;
  logic          held_nosig;
  int            valid_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic expect_win(input logic [FW-1:0] f, input logic ovf, input logic nosig);
    sb.push_back('{skip: 1'b0, freq: f, ovf: ovf, nosig: nosig});
  endtask

  task automatic expect_skip();
    sb.push_back('{skip: 1'b1, freq: '0, ovf: 1'b0, nosig: 1'b0});
  endtask

  // Waits on falling edges until o_valid is seen or the budget runs out.
  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (o_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Called with o_valid high: pops the next expectation and compares, then
  // checks that the strobe is only one cycle wide.
  task automatic compare_valid(input string tag);
    exp_t e;
    valid_cyc = cyc;
    if (sb.size() == 0) begin
      n_checks++;
      n_fails++;
      $error("FAIL %s: observed unexpected o_valid expected empty scoreboard", tag);
    end else begin
      e = sb.pop_front();
      if (!e.skip) begin
        check({tag, "_freq"},  32'(o_freq),      32'(e.freq));
        check({tag, "_ovf"},   32'(o_overflow),  32'(e.ovf));
        check({tag, "_nosig"}, 32'(o_no_signal), 32'(e.nosig));
        held_freq  = e.freq;
        held_ovf   = e.ovf;
        held_nosig = e.nosig;
      end
    end
    @(negedge clk);
    check({tag, "_pulse_width"}, 32'(o_valid), 32'd0);
  endtask

  task automatic check_next_valid(input string tag);
    int n;
    wait_valid(GATE + 200, n);
    check({tag, "_valid_seen"}, 32'(o_valid), 32'd1);
    if (o_valid === 1'b1) compare_valid(tag);
  endtask

  initial begin
    int n;
    int t0;
    int vcount;

    i_reset  = 1'b1;
    i_enable = 1'b1;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_freq",  32'(o_freq),      32'd0);
    check("rst_valid", 32'(o_valid),     32'd0);
    check("rst_ovf",   32'(o_overflow),  32'd0);
    check("rst_nosig", 32'(o_no_signal), 32'd1);
    i_reset = 1'b0;

    // Period 10 -> 100 edges per window.
    tone_period = 10;
    expect_skip();
    expect_win(8'd100, 1'b0, 1'b0);
    expect_win(8'd100, 1'b0, 1'b0);
    repeat (3) check_next_valid("p10");

    // Tone stuck low -> zero count, no_signal, strobes one window apart.
    tone_period = 0;
    tone_level  = 1'b0;
    expect_skip();
    expect_win(8'd0, 1'b0, 1'b1);
    expect_win(8'd0, 1'b0, 1'b1);
    check_next_valid("silent");
    t0 = valid_cyc;
    check_next_valid("silent");
    check("silent_gap", 32'(valid_cyc - t0), 32'(GATE));
    t0 = valid_cyc;
    check_next_valid("silent");
    check("silent_gap", 32'(valid_cyc - t0), 32'(GATE));

    // Single edge timed so its rise strobe lands on the last gate cycle:
    // counted in the closing window, the following window sees nothing.
    // We are in the second cycle of the window; the pin is driven in cycle
    // 997 of it, synchronized by cycle 999.
    repeat (996) @(negedge clk);
    tone_level = 1'b1;
    expect_win(8'd1, 1'b0, 1'b0);
    expect_win(8'd0, 1'b0, 1'b1);
    check_next_valid("last_edge");
    check_next_valid("after_last");

    // Period 2 -> 500 edges saturate the 8-bit word.
    tone_period = 2;
    expect_skip();
    expect_win(8'd255, 1'b1, 1'b0);
    check_next_valid("sat");
    check_next_valid("sat");

    // Period 20 -> 50 edges, overflow flag cleared.
    tone_period = 20;
    expect_skip();
    expect_win(8'd50, 1'b0, 1'b0);
    check_next_valid("p20");
    check_next_valid("p20");

    // Back to period 10, then reset mid-window.
    tone_period = 10;
    expect_skip();
    expect_win(8'd100, 1'b0, 1'b0);
    check_next_valid("pre_rst");
    check_next_valid("pre_rst");
    repeat (498) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    check("midrst_freq",  32'(o_freq),      32'd0);
    check("midrst_nosig", 32'(o_no_signal), 32'd1);
    check("midrst_ovf",   32'(o_overflow),  32'd0);
    check("midrst_valid", 32'(o_valid),     32'd0);
    // This falling edge is the first cycle after the reset edge.
    wait_valid(GATE + 200, n);
    check("rst_to_valid", 32'(n + 1), 32'(GATE + 1));
    expect_skip();
    expect_win(8'd100, 1'b0, 1'b0);
    if (o_valid === 1'b1) compare_valid("post_rst");
    check_next_valid("post_rst");

    // Disabled for 3000 cycles: no strobes, outputs hold the last window.
    i_enable = 1'b0;
    vcount   = 0;
    repeat (3000) begin
      @(negedge clk);
      if (o_valid === 1'b1) vcount++;
    end
    check("dis_no_valid", 32'(vcount),      32'd0);
    check("dis_freq",     32'(o_freq),      32'(held_freq));
    check("dis_ovf",      32'(o_overflow),  32'(held_ovf));
    check("dis_nosig",    32'(o_no_signal), 32'(held_nosig));

    // Enable rises; the cycle in which it is first high counts as cycle 1.
    // The synchronizer kept running, so the fresh window is exact.
    i_enable = 1'b1;
    expect_win(8'd100, 1'b0, 1'b0);
    wait_valid(GATE + 200, n);
    check("en_to_valid", 32'(n + 1), 32'(GATE + 1));
    if (o_valid === 1'b1) compare_valid("post_en");
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
